// File: rtl/trap_shaper_cfg.sv
// trap_shaper_cfg: runtime-configurable trapezoidal shaper for one ADC channel.
// Samples are written into a circular delay line. Three taps (k, l, k+l samples
// back) form the trapezoid difference d. Two cascaded accumulators with a
// pole-zero term M*d produce s. s is shifted and saturated into a signed output.
// The sample pipeline is: tap capture, d, p/M*d, s, output.
// A sample accepted at edge t therefore appears at edge t+4.
module trap_shaper_cfg #(
    parameter int W_IN  = 12,
    parameter int W_OUT = 16,
    parameter int DEPTH = 64,
    parameter int ACC_W = 32,
    parameter int M_W   = 8,
    parameter int SHIFT = 5,
    parameter int K_DEF = 6,
    parameter int L_DEF = 13,
    parameter int M_DEF = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [W_IN-1:0]            input_data,
    input  logic                       cfg_load,
    input  logic [$clog2(DEPTH)-1:0]   cfg_k,
    input  logic [$clog2(DEPTH)-1:0]   cfg_l,
    input  logic [M_W-1:0]             cfg_m,
    output logic                       cfg_err,
    output logic                       busy,
    output logic                       out_valid,
    output logic [W_OUT-1:0]           output_data,
    output logic                       out_sat
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = W_IN + 2;
    localparam logic signed [ACC_W-1:0] OUT_MAX =
        {{(ACC_W-W_OUT+1){1'b0}}, {(W_OUT-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OUT_MIN = ~OUT_MAX;

    typedef enum logic [0:0] {
        ST_FLUSH = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // A configuration is usable only if 1 <= k <= l and the oldest tap (k+l)
    // still lies inside the delay line without aliasing the write slot.
    function automatic logic cfg_is_valid(input logic [AW-1:0] k, input logic [AW-1:0] l);
        logic [AW:0] sum;
        sum = {1'b0, k} + {1'b0, l};
        cfg_is_valid = (k != {AW{1'b0}}) && (k <= l) && (sum <= (AW+1)'(DEPTH-1));
    endfunction

    // Delay line and configuration
    logic [W_IN-1:0]          r_ram [DEPTH];
    logic [AW-1:0]            r_wp;
    logic [AW-1:0]            r_k;
    logic [AW-1:0]            r_l;
    logic [M_W-1:0]           r_m;
    logic [AW-1:0]            r_fcnt;
    state_t                   r_state;
    state_t                   w_state_nxt;

    // Control decode
    logic                     w_cfg_ok;
    logic                     w_cfg_bad;
    logic                     w_run_acc;
    logic                     w_flush_last;
    logic [AW:0]              w_kl_sum;
    logic [AW:0]              w_fcnt_inc;
    logic [AW-1:0]            w_a_k;
    logic [AW-1:0]            w_a_l;
    logic [AW-1:0]            w_a_kl;

    // Datapath
    logic [W_IN-1:0]          r_x;
    logic [W_IN-1:0]          r_xk;
    logic [W_IN-1:0]          r_xl;
    logic [W_IN-1:0]          r_xkl;
    logic                     r_v0;
    logic                     r_v1;
    logic                     r_v2;
    logic                     r_v3;
    logic signed [DW-1:0]     w_d;
    logic signed [DW-1:0]     r_d;
    logic signed [ACC_W-1:0]  w_d_ext;
    logic signed [ACC_W-1:0]  w_m_ext;
    logic signed [ACC_W-1:0]  w_md;
    logic signed [ACC_W-1:0]  r_p;
    logic signed [ACC_W-1:0]  r_md;
    logic signed [ACC_W-1:0]  r_s;
    logic signed [ACC_W-1:0]  w_y_wide;
    logic [W_OUT-1:0]         w_y;
    logic                     w_sat;

    // Decode configuration requests, flush progress and tap addresses
    always_comb begin
        w_cfg_ok     = 1'b0;
        w_cfg_bad    = 1'b0;
        w_run_acc    = 1'b0;
        w_kl_sum     = {1'b0, r_k} + {1'b0, r_l};
        w_fcnt_inc   = {1'b0, r_fcnt} + {{AW{1'b0}}, 1'b1};
        w_flush_last = (w_fcnt_inc == w_kl_sum);
        w_a_k        = r_wp - r_k;
        w_a_l        = r_wp - r_l;
        w_a_kl       = r_wp - r_k - r_l;
        if (cfg_load) begin
            w_cfg_ok  = cfg_is_valid(cfg_k, cfg_l);
            w_cfg_bad = !cfg_is_valid(cfg_k, cfg_l);
        end else begin
            w_cfg_ok  = 1'b0;
            w_cfg_bad = 1'b0;
        end
        // A valid configuration takes precedence over a coincident sample.
        w_run_acc = in_valid && (r_state == ST_RUN) && !w_cfg_ok;
    end

    // Next-state logic: a valid reconfiguration always restarts the flush
    always_comb begin
        w_state_nxt = r_state;
        if (w_cfg_ok) begin
            w_state_nxt = ST_FLUSH;
        end else begin
            case (r_state)
                ST_FLUSH: begin
                    if (in_valid && w_flush_last) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_state_nxt = ST_FLUSH;
                    end
                end
                ST_RUN:   w_state_nxt = ST_RUN;
                default:  w_state_nxt = ST_FLUSH;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_FLUSH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Active configuration and flush sample counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_k    <= AW'(K_DEF);
            r_l    <= AW'(L_DEF);
            r_m    <= M_W'(M_DEF);
            r_fcnt <= {AW{1'b0}};
        end else if (w_cfg_ok) begin
            r_k    <= cfg_k;
            r_l    <= cfg_l;
            r_m    <= cfg_m;
            // A coincident sample counts as the first flush sample.
            r_fcnt <= {{(AW-1){1'b0}}, in_valid};
        end else if ((r_state == ST_FLUSH) && in_valid) begin
            r_fcnt <= w_flush_last ? {AW{1'b0}} : w_fcnt_inc[AW-1:0];
        end
    end

    // Delay-line storage; contents deliberately survive reset and reconfiguration
    always_ff @(posedge clk) begin
        if (in_valid) begin
            r_ram[r_wp] <= input_data;
        end
    end

    // Write pointer advances on every accepted sample, wrapping modulo DEPTH
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wp <= {AW{1'b0}};
        end else if (in_valid) begin
            r_wp <= r_wp + {{(AW-1){1'b0}}, 1'b1};
        end
    end

    // Stage 0: capture the new sample and its three delayed taps
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_v0  <= 1'b0;
            r_x   <= {W_IN{1'b0}};
            r_xk  <= {W_IN{1'b0}};
            r_xl  <= {W_IN{1'b0}};
            r_xkl <= {W_IN{1'b0}};
        end else begin
            r_v0 <= w_run_acc;
            if (w_run_acc) begin
                r_x   <= input_data;
                r_xk  <= r_ram[w_a_k];
                r_xl  <= r_ram[w_a_l];
                r_xkl <= r_ram[w_a_kl];
            end
        end
    end

    // Trapezoid difference on zero-extended samples, then sign/zero extension for the accumulators
    always_comb begin
        w_d     = $signed({2'b00, r_x}) - $signed({2'b00, r_xk})
                - $signed({2'b00, r_xl}) + $signed({2'b00, r_xkl});
        w_d_ext = {{(ACC_W-DW){r_d[DW-1]}}, r_d};
        w_m_ext = {{(ACC_W-M_W){1'b0}}, r_m};
        w_md    = w_m_ext * w_d_ext;
    end

    // Stage 1: register d
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_v1 <= 1'b0;
            r_d  <= {DW{1'b0}};
        end else if (w_cfg_ok) begin
            r_v1 <= 1'b0;
        end else begin
            r_v1 <= r_v0;
            if (r_v0) begin
                r_d <= w_d;
            end
        end
    end

    // Stage 2: first accumulator p and the pole-zero product M*d
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_v2 <= 1'b0;
            r_p  <= {ACC_W{1'b0}};
            r_md <= {ACC_W{1'b0}};
        end else if (w_cfg_ok) begin
            r_v2 <= 1'b0;
            r_p  <= {ACC_W{1'b0}};
        end else begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_p  <= r_p + w_d_ext;
                r_md <= w_md;
            end
        end
    end

    // Stage 3: second accumulator s += p + M*d
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_v3 <= 1'b0;
            r_s  <= {ACC_W{1'b0}};
        end else if (w_cfg_ok) begin
            r_v3 <= 1'b0;
            r_s  <= {ACC_W{1'b0}};
        end else begin
            r_v3 <= r_v2;
            if (r_v2) begin
                r_s <= r_s + r_p + r_md;
            end
        end
    end

    // Arithmetic scaling and clipping to the signed output range
    always_comb begin
        w_y_wide = r_s >>> SHIFT;
        w_y      = w_y_wide[W_OUT-1:0];
        w_sat    = 1'b0;
        if (w_y_wide > OUT_MAX) begin
            w_y   = {1'b0, {(W_OUT-1){1'b1}}};
            w_sat = 1'b1;
        end else if (w_y_wide < OUT_MIN) begin
            w_y   = {1'b1, {(W_OUT-1){1'b0}}};
            w_sat = 1'b1;
        end else begin
            w_y   = w_y_wide[W_OUT-1:0];
            w_sat = 1'b0;
        end
    end

    // Stage 4: registered output; in-flight samples are dropped on reconfiguration
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid   <= 1'b0;
            output_data <= {W_OUT{1'b0}};
            out_sat     <= 1'b0;
        end else if (w_cfg_ok) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= r_v3;
            if (r_v3) begin
                output_data <= w_y;
                out_sat     <= w_sat;
            end
        end
    end

    // Status outputs: rejection pulse and flush indicator
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cfg_err <= 1'b0;
            busy    <= 1'b1;
        end else begin
            cfg_err <= w_cfg_bad;
            busy    <= (w_state_nxt == ST_FLUSH);
        end
    end

endmodule
